// File: rtl/ls_issue_queue_pkg.sv
// Shared types for the load/store issue queue: CDB bus, issue bundle, opcodes.
package ls_issue_queue_pkg;

  localparam int LSQ_TAG_W = 6;

  localparam logic OP_SW = 1'b1;
  localparam logic OP_LW = 1'b0;

  typedef struct packed {
    logic                 valid;
    logic [LSQ_TAG_W-1:0] tag;
    logic [31:0]          data;
  } cdb_bus_t;

  typedef struct packed {
    logic                 issueblk_done;
    logic                 issueque_opcode;
    logic [31:0]          issueque_rs_data;
    logic [31:0]          issueque_imm;
    logic [31:0]          issueque_rt_data;
    logic [LSQ_TAG_W-1:0] issueque_rd_tag;
  } mem_data_exec_unit_t;

  function automatic logic cdb_hit(input cdb_bus_t cdb, input logic [LSQ_TAG_W-1:0] tag);
    return cdb.valid && (cdb.tag == tag);
  endfunction

endpackage

// File: rtl/ls_queue_entry.sv
// One issue-queue slot: operand storage plus CDB tag compare/capture,
// including same-cycle capture of a result broadcast while the entry is written.
module ls_queue_entry
  import ls_issue_queue_pkg::*;
#(
  parameter int TAG_W = LSQ_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic             clr_i,
  input  logic             opcode_i,
  input  logic [31:0]      rs_data_i,
  input  logic [TAG_W-1:0] rs_tag_i,
  input  logic             rs_valid_i,
  input  logic [31:0]      rt_data_i,
  input  logic [TAG_W-1:0] rt_tag_i,
  input  logic             rt_valid_i,
  input  logic [31:0]      imm_i,
  input  logic [TAG_W-1:0] rd_tag_i,
  input  cdb_bus_t         cdb_i,
  output logic             valid_o,
  output logic             opcode_o,
  output logic [31:0]      rs_data_o,
  output logic             rs_valid_o,
  output logic [31:0]      rt_data_o,
  output logic             rt_valid_o,
  output logic [31:0]      imm_o,
  output logic [TAG_W-1:0] rd_tag_o
);

  logic             valid_q, valid_d;
  logic             rs_valid_q, rs_valid_d;
  logic             rt_valid_q, rt_valid_d;
  logic             opcode_q, opcode_d;
  logic [31:0]      rs_data_q, rs_data_d;
  logic [31:0]      rt_data_q, rt_data_d;
  logic [31:0]      imm_q, imm_d;
  logic [TAG_W-1:0] rs_tag_q, rs_tag_d;
  logic [TAG_W-1:0] rt_tag_q, rt_tag_d;
  logic [TAG_W-1:0] rd_tag_q, rd_tag_d;

  logic rs_hit_new, rt_hit_new, rs_hit_q, rt_hit_q;

  assign rs_hit_new = cdb_hit(cdb_i, LSQ_TAG_W'(rs_tag_i));
  assign rt_hit_new = cdb_hit(cdb_i, LSQ_TAG_W'(rt_tag_i));
  assign rs_hit_q   = cdb_hit(cdb_i, LSQ_TAG_W'(rs_tag_q));
  assign rt_hit_q   = cdb_hit(cdb_i, LSQ_TAG_W'(rt_tag_q));

  always_comb begin
    valid_d    = valid_q;
    rs_valid_d = rs_valid_q;
    rt_valid_d = rt_valid_q;
    opcode_d   = opcode_q;
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    imm_d      = imm_q;
    rs_tag_d   = rs_tag_q;
    rt_tag_d   = rt_tag_q;
    rd_tag_d   = rd_tag_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (wr_en_i) begin
      valid_d    = 1'b1;
      opcode_d   = opcode_i;
      imm_d      = imm_i;
      rs_tag_d   = rs_tag_i;
      rt_tag_d   = rt_tag_i;
      rd_tag_d   = rd_tag_i;
      rs_valid_d = rs_valid_i | rs_hit_new;
      rt_valid_d = rt_valid_i | rt_hit_new;
      rs_data_d  = (!rs_valid_i && rs_hit_new) ? cdb_i.data : rs_data_i;
      rt_data_d  = (!rt_valid_i && rt_hit_new) ? cdb_i.data : rt_data_i;
    end else begin
      if (clr_i) valid_d = 1'b0;
      if (valid_q && !rs_valid_q && rs_hit_q) begin
        rs_valid_d = 1'b1;
        rs_data_d  = cdb_i.data;
      end
      if (valid_q && !rt_valid_q && rt_hit_q) begin
        rt_valid_d = 1'b1;
        rt_data_d  = cdb_i.data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      rs_valid_q <= 1'b0;
      rt_valid_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rs_valid_q <= rs_valid_d;
      rt_valid_q <= rt_valid_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    opcode_q  <= opcode_d;
    rs_data_q <= rs_data_d;
    rt_data_q <= rt_data_d;
    imm_q     <= imm_d;
    rs_tag_q  <= rs_tag_d;
    rt_tag_q  <= rt_tag_d;
    rd_tag_q  <= rd_tag_d;
  end

  assign valid_o    = valid_q;
  assign opcode_o   = opcode_q;
  assign rs_data_o  = rs_data_q;
  assign rs_valid_o = rs_valid_q;
  assign rt_data_o  = rt_data_q;
  assign rt_valid_o = rt_valid_q;
  assign imm_o      = imm_q;
  assign rd_tag_o   = rd_tag_q;

endmodule

// File: rtl/ls_issue_queue.sv
// In-order load/store issue queue: circular buffer of ls_queue_entry slots,
// head-only issue into a registered memory-unit bundle.
module ls_issue_queue
  import ls_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = LSQ_TAG_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dispatch_en,
  input  logic                dispatch_opcode,
  input  logic [31:0]         dispatch_rs_data,
  input  logic [TAG_W-1:0]    dispatch_rs_tag,
  input  logic                dispatch_rs_valid,
  input  logic [31:0]         dispatch_rt_data,
  input  logic [TAG_W-1:0]    dispatch_rt_tag,
  input  logic                dispatch_rt_valid,
  input  logic [31:0]         dispatch_imm,
  input  logic [TAG_W-1:0]    dispatch_rd_tag,
  input  logic                cdb_valid,
  input  logic [TAG_W-1:0]    cdb_tag,
  input  logic [31:0]         cdb_data,
  input  logic                cdb_grant_mem,
  input  logic                flush,
  output logic                ls_queue_full,
  output logic                ls_queue_empty,
  output mem_data_exec_unit_t mem_data_exec_unit
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   head_q, head_d, tail_q, tail_d, count;
  logic [PTR_W-1:0] hidx, tidx;
  logic             dispatch_ok, head_ready, issue;
  cdb_bus_t         cdb;

  mem_data_exec_unit_t out_q, out_d;

  logic             ent_valid    [DEPTH];
  logic             ent_opcode   [DEPTH];
  logic [31:0]      ent_rs_data  [DEPTH];
  logic             ent_rs_valid [DEPTH];
  logic [31:0]      ent_rt_data  [DEPTH];
  logic             ent_rt_valid [DEPTH];
  logic [31:0]      ent_imm      [DEPTH];
  logic [TAG_W-1:0] ent_rd_tag   [DEPTH];

  assign cdb = '{valid: cdb_valid, tag: LSQ_TAG_W'(cdb_tag), data: cdb_data};

  // Extra pointer MSB separates full from empty when the low bits match.
  assign count          = tail_q - head_q;
  assign ls_queue_full  = (count == (PTR_W+1)'(DEPTH));
  assign ls_queue_empty = (count == '0);
  assign hidx           = head_q[PTR_W-1:0];
  assign tidx           = tail_q[PTR_W-1:0];
  assign dispatch_ok    = dispatch_en && !ls_queue_full && !flush;

  assign head_ready = ent_valid[hidx] && ent_rs_valid[hidx] &&
                      ((ent_opcode[hidx] == OP_SW) ? ent_rt_valid[hidx] : cdb_grant_mem);
  assign issue      = head_ready && !flush;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (issue)       head_d = head_q + 1'b1;
      if (dispatch_ok) tail_d = tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    ls_queue_entry #(.TAG_W(TAG_W)) u_entry (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (flush),
      .wr_en_i    (dispatch_ok && (tidx == PTR_W'(g))),
      .clr_i      (issue && (hidx == PTR_W'(g))),
      .opcode_i   (dispatch_opcode),
      .rs_data_i  (dispatch_rs_data),
      .rs_tag_i   (dispatch_rs_tag),
      .rs_valid_i (dispatch_rs_valid),
      .rt_data_i  (dispatch_rt_data),
      .rt_tag_i   (dispatch_rt_tag),
      .rt_valid_i (dispatch_rt_valid),
      .imm_i      (dispatch_imm),
      .rd_tag_i   (dispatch_rd_tag),
      .cdb_i      (cdb),
      .valid_o    (ent_valid[g]),
      .opcode_o   (ent_opcode[g]),
      .rs_data_o  (ent_rs_data[g]),
      .rs_valid_o (ent_rs_valid[g]),
      .rt_data_o  (ent_rt_data[g]),
      .rt_valid_o (ent_rt_valid[g]),
      .imm_o      (ent_imm[g]),
      .rd_tag_o   (ent_rd_tag[g])
    );
  end

  // Data fields hold their last issued values; only done pulses.
  always_comb begin
    out_d               = out_q;
    out_d.issueblk_done = issue;
    if (issue) begin
      out_d.issueque_opcode  = ent_opcode[hidx];
      out_d.issueque_rs_data = ent_rs_data[hidx];
      out_d.issueque_imm     = ent_imm[hidx];
      out_d.issueque_rt_data = ent_rt_data[hidx];
      out_d.issueque_rd_tag  = LSQ_TAG_W'(ent_rd_tag[hidx]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign mem_data_exec_unit = out_q;

endmodule

// File: tb/tb_ls_issue_queue.sv
// Directed-vector bench for ls_issue_queue with hand-computed expectations.
module tb_ls_issue_queue;
  import ls_issue_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        dispatch_en, dispatch_opcode, dispatch_rs_valid, dispatch_rt_valid;
  logic [31:0] dispatch_rs_data, dispatch_rt_data, dispatch_imm, cdb_data;
  logic [5:0]  dispatch_rs_tag, dispatch_rt_tag, dispatch_rd_tag, cdb_tag;
  logic        cdb_valid, cdb_grant_mem, flush;
  logic        ls_queue_full, ls_queue_empty;
  mem_data_exec_unit_t mem_data_exec_unit;

  int nvec = 0;
  int nmis = 0;

  ls_issue_queue #(.DEPTH(4), .TAG_W(6)) dut (
    .clk               (clk),
    .rst               (rst),
    .dispatch_en       (dispatch_en),
    .dispatch_opcode   (dispatch_opcode),
    .dispatch_rs_data  (dispatch_rs_data),
    .dispatch_rs_tag   (dispatch_rs_tag),
    .dispatch_rs_valid (dispatch_rs_valid),
    .dispatch_rt_data  (dispatch_rt_data),
    .dispatch_rt_tag   (dispatch_rt_tag),
    .dispatch_rt_valid (dispatch_rt_valid),
    .dispatch_imm      (dispatch_imm),
    .dispatch_rd_tag   (dispatch_rd_tag),
    .cdb_valid         (cdb_valid),
    .cdb_tag           (cdb_tag),
    .cdb_data          (cdb_data),
    .cdb_grant_mem     (cdb_grant_mem),
    .flush             (flush),
    .ls_queue_full     (ls_queue_full),
    .ls_queue_empty    (ls_queue_empty),
    .mem_data_exec_unit(mem_data_exec_unit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic op, input logic [31:0] rs, input logic [5:0] rs_tag,
                      input logic rs_v, input logic [31:0] rt, input logic [5:0] rt_tag,
                      input logic rt_v, input logic [31:0] imm, input logic [5:0] rd);
    dispatch_en       = 1'b1;
    dispatch_opcode   = op;
    dispatch_rs_data  = rs;
    dispatch_rs_tag   = rs_tag;
    dispatch_rs_valid = rs_v;
    dispatch_rt_data  = rt;
    dispatch_rt_tag   = rt_tag;
    dispatch_rt_valid = rt_v;
    dispatch_imm      = imm;
    dispatch_rd_tag   = rd;
  endtask

  task automatic cdb(input logic v, input logic [5:0] tag, input logic [31:0] data);
    cdb_valid = v;
    cdb_tag   = tag;
    cdb_data  = data;
  endtask

  task automatic expect_issue(input string tag, input logic [5:0] rd);
    chk({tag, "_done"}, 32'(mem_data_exec_unit.issueblk_done), 32'd1);
    chk({tag, "_rd"}, 32'(mem_data_exec_unit.issueque_rd_tag), 32'(rd));
  endtask

  logic [5:0] order [11];

  initial begin
    order = '{6'd11, 6'd12, 6'd13, 6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27};
    rst = 1'b1;
    disp(1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
    dispatch_en = 1'b0;
    cdb(1'b0, 0, 0);
    cdb_grant_mem = 1'b0;
    flush = 1'b0;
    tick(); tick();
    chk("rst_full", 32'(ls_queue_full), 32'd0);
    chk("rst_empty", 32'(ls_queue_empty), 32'd1);
    chk("rst_bundle_lo", mem_data_exec_unit[31:0], 32'd0);
    chk("rst_done", 32'(mem_data_exec_unit.issueblk_done), 32'd0);
    rst = 1'b0;
    tick();

    // LW with ready base and grant: done two edges after dispatch
    cdb_grant_mem = 1'b1;
    disp(OP_LW, 32'h10, 0, 1'b1, 0, 0, 1'b0, 32'h4, 6'd3);
    tick();
    dispatch_en = 1'b0;
    chk("lw_empty_n", 32'(ls_queue_empty), 32'd0);
    chk("lw_early", 32'(mem_data_exec_unit.issueblk_done), 32'd0);
    tick();
    expect_issue("lw", 6'd3);
    chk("lw_rs", mem_data_exec_unit.issueque_rs_data, 32'h10);
    chk("lw_imm", mem_data_exec_unit.issueque_imm, 32'h4);
    chk("lw_op", 32'(mem_data_exec_unit.issueque_opcode), 32'd0);
    tick();
    chk("lw_pulse", 32'(mem_data_exec_unit.issueblk_done), 32'd0);
    chk("lw_empty", 32'(ls_queue_empty), 32'd1);

    // SW waits for rt tag 5 from the CDB
    cdb_grant_mem = 1'b0;
    disp(OP_SW, 32'h100, 0, 1'b1, 0, 6'd5, 1'b0, 32'h8, 6'd6);
    tick();
    dispatch_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sw_wait", 32'(mem_data_exec_unit.issueblk_done), 32'd0);
    end
    cdb(1'b1, 6'd5, 32'hDEAD);
    tick();
    cdb(1'b0, 0, 0);
    chk("sw_capture_cyc", 32'(mem_data_exec_unit.issueblk_done), 32'd0);
    tick();
    chk("sw_done", 32'(mem_data_exec_unit.issueblk_done), 32'd1);
    chk("sw_rt", mem_data_exec_unit.issueque_rt_data, 32'hDEAD);
    chk("sw_op", 32'(mem_data_exec_unit.issueque_opcode), 32'd1);

    // In-order: LW A (rs tag 9 pending) blocks ready LW B
    cdb_grant_mem = 1'b1;
    disp(OP_LW, 0, 6'd9, 1'b0, 0, 0, 1'b0, 0, 6'd1);
    tick();
    disp(OP_LW, 32'h20, 0, 1'b1, 0, 0, 1'b0, 0, 6'd2);
    tick();
    dispatch_en = 1'b0;
    tick();
    chk("ord_block", 32'(mem_data_exec_unit.issueblk_done), 32'd0);
    cdb(1'b1, 6'd9, 32'h30);
    tick();
    cdb(1'b0, 0, 0);
    chk("ord_block2", 32'(mem_data_exec_unit.issueblk_done), 32'd0);
    tick();
    expect_issue("ord_a", 6'd1);
    chk("ord_a_rs", mem_data_exec_unit.issueque_rs_data, 32'h30);
    tick();
    expect_issue("ord_b", 6'd2);
    chk("ord_b_rs", mem_data_exec_unit.issueque_rs_data, 32'h20);
    tick();
    chk("ord_idle", 32'(mem_data_exec_unit.issueblk_done), 32'd0);

    // Fill, reject fifth, then stream through wrap-around
    cdb_grant_mem = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("fill_notfull", 32'(ls_queue_full), 32'd0);
      disp(OP_LW, 32'(i), 0, 1'b1, 0, 0, 1'b0, 0, 6'(10 + i));
      tick();
    end
    chk("fill_full", 32'(ls_queue_full), 32'd1);
    disp(OP_LW, 0, 0, 1'b1, 0, 0, 1'b0, 0, 6'd14);
    tick();
    dispatch_en = 1'b0;
    chk("fill_reject", 32'(ls_queue_full), 32'd1);
    cdb_grant_mem = 1'b1;
    tick();
    cdb_grant_mem = 1'b0;
    expect_issue("fill_first", 6'd10);
    chk("fill_drop", 32'(ls_queue_full), 32'd0);
    cdb_grant_mem = 1'b1;
    for (int i = 0; i < 8; i++) begin
      disp(OP_LW, 0, 0, 1'b1, 0, 0, 1'b0, 0, 6'(20 + i));
      tick();
      expect_issue("wrap", order[i]);
      chk("wrap_notfull", 32'(ls_queue_full), 32'd0);
    end
    dispatch_en = 1'b0;
    for (int i = 8; i < 11; i++) begin
      tick();
      expect_issue("drain", order[i]);
    end
    tick();
    chk("drain_idle", 32'(mem_data_exec_unit.issueblk_done), 32'd0);
    chk("drain_empty", 32'(ls_queue_empty), 32'd1);

    // Same-cycle CDB bypass at dispatch
    disp(OP_LW, 0, 6'd7, 1'b0, 0, 0, 1'b0, 0, 6'd8);
    cdb(1'b1, 6'd7, 32'h40);
    tick();
    dispatch_en = 1'b0;
    cdb(1'b0, 0, 0);
    tick();
    expect_issue("bypass", 6'd8);
    chk("bypass_rs", mem_data_exec_unit.issueque_rs_data, 32'h40);

    // Flush with concurrent dispatch
    cdb_grant_mem = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp(OP_LW, 0, 0, 1'b1, 0, 0, 1'b0, 0, 6'(30 + i));
      tick();
    end
    disp(OP_LW, 0, 0, 1'b1, 0, 0, 1'b0, 0, 6'd33);
    flush = 1'b1;
    cdb_grant_mem = 1'b1;
    tick();
    flush = 1'b0;
    dispatch_en = 1'b0;
    chk("flush_empty", 32'(ls_queue_empty), 32'd1);
    chk("flush_done", 32'(mem_data_exec_unit.issueblk_done), 32'd0);
    tick();
    chk("flush_noissue", 32'(mem_data_exec_unit.issueblk_done), 32'd0);
    disp(OP_LW, 0, 0, 1'b1, 0, 0, 1'b0, 0, 6'd34);
    tick();
    dispatch_en = 1'b0;
    tick();
    expect_issue("post_flush", 6'd34);

    // Asynchronous reset mid-operation
    cdb_grant_mem = 1'b0;
    disp(OP_LW, 0, 0, 1'b1, 0, 0, 1'b0, 0, 6'd40);
    tick();
    dispatch_en = 1'b0;
    chk("arst_pre", 32'(ls_queue_empty), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_empty", 32'(ls_queue_empty), 32'd1);
    chk("arst_rd", 32'(mem_data_exec_unit.issueque_rd_tag), 32'd0);
    tick();
    rst = 1'b0;
    cdb_grant_mem = 1'b1;
    tick(); tick();
    chk("arst_noissue", 32'(mem_data_exec_unit.issueblk_done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/ls_issue_queue.md
# ls_issue_queue

In-order load/store issue queue for the Tomasulo back end. Entries arrive from dispatch with renamed source operands, wait for missing operands by snooping the CDB, and issue strictly in program order. The oldest ready entry is presented to the memory execution unit as a registered one-cycle `mem_data_exec_unit` bundle. Stores retire silently at issue; loads occupy the CDB slot granted by the arbiter.

## Interface

Parameters:
- DEPTH, 4: number of queue entries; power of two, ≥2.
- TAG_W, 6: ROB/physical tag width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- dispatch_en  in  1  write one entry this cycle; ignored while ls_queue_full=1.
- dispatch_opcode  in  1  1=SW, 0=LW.
- dispatch_rs_data / dispatch_rs_tag / dispatch_rs_valid  in  32 / TAG_W / 1  base-address operand; valid=1 means data present.
- dispatch_rt_data / dispatch_rt_tag / dispatch_rt_valid  in  32 / TAG_W / 1  store-data operand; don't-care for LW.
- dispatch_imm  in  32  sign-extended offset.
- dispatch_rd_tag  in  TAG_W  destination tag (LW only).
- cdb_valid / cdb_tag / cdb_data  in  1 / TAG_W / 32  broadcast result bus.
- cdb_grant_mem  in  1  arbiter grants the CDB to the memory unit for the next cycle.
- flush  in  1  synchronous mispredict flush; empties the queue.
- ls_queue_full  out  1  count==DEPTH.
- ls_queue_empty  out  1  count==0.
- mem_data_exec_unit  out  struct  issueblk_done, issueque_opcode, issueque_rs_data, issueque_imm, issueque_rt_data, issueque_rd_tag; all registered.

## Operation

- Circular buffer: head/tail pointers of log2(DEPTH)+1 bits. The MSB distinguishes full from empty on wrap-around. Count = tail−head (modulo).
- Dispatch: with dispatch_en & !ls_queue_full, write the entry at tail and increment tail.
  - Same-cycle bypass: if cdb_valid and cdb_tag equals a dispatched invalid tag, the entry stores cdb_data with valid=1.
- Snoop: every valid entry with an invalid operand whose tag equals cdb_tag while cdb_valid=1 captures cdb_data and sets that operand valid.
- Readiness comes from stored state only; there is no combinational forward from the CDB into the issue decision.
  - SW ready: rs_valid & rt_valid.
  - LW ready: rs_valid & cdb_grant_mem.
- Issue: only the head entry may issue. If ready, load the output register with the head fields, set issueblk_done=1, and increment head.
  - Otherwise issueblk_done=0 and the data fields hold their last values.
- Dispatch and issue in the same cycle both take effect. ls_queue_full is evaluated before issue, so a full queue rejects dispatch even when the head issues that cycle.
- Flush: head=tail=0, all entry valids cleared, issueblk_done=0 next cycle. Flush overrides dispatch and issue in the same cycle.

## Timing

- Reset values:
  - ls_queue_full=0, ls_queue_empty=1.
  - All mem_data_exec_unit fields 0, including issueblk_done=0.
  - Pointers 0, entry valids 0.
- Rst asserted mid-operation discards all entries immediately (asynchronous).
- Dispatch at edge N: entry visible at N+1. Earliest issue decision in cycle N+1; issueblk_done high in cycle N+2.
- CDB capture at edge M: operand ready in cycle M+1.
- issueblk_done is a single-cycle pulse per issued entry. Back-to-back issue (one per cycle) is allowed.
- ls_queue_full and ls_queue_empty are registered-state derived and valid from cycle 0 after reset.

## Structure

- Shared package (variables.sv): the mem_data_exec_unit struct and the cdb_bus struct, plus TAG_W and the SW/LW opcode constants.
- Natural sub-module: ls_queue_entry.
  - Holds one entry's storage and its CDB tag compare/capture.
  - Instantiated DEPTH times in a generate loop.
- Top level holds the pointers, full/empty logic, head mux and output register.

## Test plan

- Reset, then dispatch LW with rs valid (rs=0x10, imm=0x4, rd_tag=3) and cdb_grant_mem=1 -> issueblk_done=1 two cycles later with rs_data=0x10, imm=0x4, rd_tag=3, opcode=0.
- Dispatch SW with rt tag 5 invalid, then CDB broadcasts tag 5, data 0xDEAD -> SW issues the cycle after capture with rt_data=0xDEAD, opcode=1; it never issues before capture.
- Dispatch LW(A, not ready) then LW(B, ready) -> B does not issue until A issues; order is A then B in consecutive cycles.
- Fill all 4 entries -> ls_queue_full=1 and a 5th dispatch is ignored. Issue one -> full drops. Dispatch 8 more through wrap-around -> issue order and count stay correct.
- Dispatch with rs_tag=7 invalid while cdb_valid=1, cdb_tag=7, cdb_data=0x40 -> entry captures 0x40 and is ready the next cycle.
- Queue holding 3 entries, assert flush concurrently with dispatch_en -> empty=1 next cycle, no issueblk_done, dispatched entry dropped.
